// File: rtl/efpga_tcdm_l2_bridge_if.sv
// TCDM-style request/response channel used on both sides of the eFPGA-to-L2 bridge.
// The bridge is a slave towards the eFPGA subsystem and a master towards L2.
interface efpga_tcdm_l2_bridge_if;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        r_valid;
  logic [31:0] r_rdata;

  modport master (
    output req, add, wen, be, wdata,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, add, wen, be, wdata,
    output gnt, r_valid, r_rdata
  );
endinterface

// File: rtl/efpga_tcdm_l2_bridge.sv
// Per-port bridge from an eFPGA TCDM master to the L2 interconnect: request FIFO,
// outstanding-transaction cap, fixed upper address bits, drain on disable, stray-response flag.
module efpga_tcdm_l2_bridge #(
  parameter int unsigned            DEPTH      = 4,
  parameter int unsigned            MAX_OUTST  = 2,
  parameter int unsigned            ADDR_WIDTH = 20,
  parameter logic [31-ADDR_WIDTH:0] BASE_HI    = 12'h1C0
) (
  input  logic                          asic_clk_i,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          clr_err_i,
  efpga_tcdm_l2_bridge_if.slave         s_port,
  efpga_tcdm_l2_bridge_if.master        l2_port,
  output logic                          idle_o,
  output logic                          err_unexp_o
);

  localparam int unsigned PTR_W       = $clog2(DEPTH);
  localparam logic [2:0]  MAX_OUTST_C = 3'(MAX_OUTST);
  localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                r_state;
  logic [PTR_W:0]        r_wr_ptr;
  logic [PTR_W:0]        r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_add_q   [DEPTH];
  logic                  r_wen_q   [DEPTH];
  logic [3:0]            r_be_q    [DEPTH];
  logic [31:0]           r_wdata_q [DEPTH];
  logic [2:0]            r_outst;
  logic                  r_err;
  logic                  r_rvalid;
  logic [31:0]           r_rdata;

  logic [PTR_W-1:0]      w_wr_idx;
  logic [PTR_W-1:0]      w_rd_idx;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_gnt;
  logic                  w_push;
  logic                  w_l2_req;
  logic                  w_pop;
  logic                  w_resp;
  logic                  w_stray;
  logic                  w_idle;
  logic                  w_unused_add;

  assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
  assign w_rd_idx = r_rd_ptr[PTR_W-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  // Full blocks the grant even when the head is popped in the same cycle.
  assign w_gnt    = enable_i & ~w_full;
  assign w_push   = s_port.req & w_gnt;
  assign w_l2_req = ~w_empty & (r_outst < MAX_OUTST_C) & (r_state != ST_IDLE);
  assign w_pop    = w_l2_req & l2_port.gnt;
  assign w_resp   = l2_port.r_valid;
  assign w_stray  = w_resp & (r_outst == 3'd0);
  assign w_idle   = w_empty & (r_outst == 3'd0);

  assign w_unused_add = ^s_port.add[31:ADDR_WIDTH];

  // FIFO storage; the head entry is always visible on the L2 side.
  always_ff @(posedge asic_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_add_q[i]   <= '0;
        r_wen_q[i]   <= 1'b1;
        r_be_q[i]    <= 4'h0;
        r_wdata_q[i] <= 32'h0000_0000;
      end
    end else if (w_push) begin
      r_add_q[w_wr_idx]   <= s_port.add[ADDR_WIDTH-1:0];
      r_wen_q[w_wr_idx]   <= s_port.wen;
      r_be_q[w_wr_idx]    <= s_port.be;
      r_wdata_q[w_wr_idx] <= s_port.wdata;
    end
  end

  // FIFO pointers carry a wrap bit so full and empty can be told apart.
  always_ff @(posedge asic_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Outstanding counter; a stray response never drives it below zero.
  always_ff @(posedge asic_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_outst <= 3'd0;
    end else begin
      case ({w_pop, w_resp & ~w_stray})
        2'b10:   r_outst <= r_outst + 3'd1;
        2'b01:   r_outst <= r_outst - 3'd1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Sticky stray-response flag; a new stray wins over a simultaneous clear.
  always_ff @(posedge asic_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_stray) begin
      r_err <= 1'b1;
    end else if (clr_err_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err;
    end
  end

  // Response path: one-cycle registered copy, forwarded regardless of state.
  always_ff @(posedge asic_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0000_0000;
    end else begin
      r_rvalid <= l2_port.r_valid;
      r_rdata  <= l2_port.r_rdata;
    end
  end

  // Control FSM; DRAIN keeps issuing queued entries until the bridge is idle.
  always_ff @(posedge asic_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable_i) r_state <= ST_RUN;
          else          r_state <= ST_IDLE;
        end
        ST_RUN: begin
          if (enable_i)    r_state <= ST_RUN;
          else if (w_idle) r_state <= ST_IDLE;
          else             r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (enable_i)    r_state <= ST_RUN;
          else if (w_idle) r_state <= ST_IDLE;
          else             r_state <= ST_DRAIN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_port.gnt      = w_gnt;
  assign s_port.r_valid  = r_rvalid;
  assign s_port.r_rdata  = r_rdata;

  assign l2_port.req     = w_l2_req;
  assign l2_port.add     = {BASE_HI, r_add_q[w_rd_idx]};
  assign l2_port.wen     = r_wen_q[w_rd_idx];
  assign l2_port.be      = r_be_q[w_rd_idx];
  assign l2_port.wdata   = r_wdata_q[w_rd_idx];

  assign idle_o          = w_idle;
  assign err_unexp_o     = r_err;

endmodule

// File: tb/tb_efpga_tcdm_l2_bridge.sv
// Directed self-checking bench for efpga_tcdm_l2_bridge with default parameters
// (DEPTH=4, MAX_OUTST=2, ADDR_WIDTH=20, BASE_HI=12'h1C0).
module tb_efpga_tcdm_l2_bridge;
  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic clr_err;
  logic idle;
  logic err;
  int   n_checks = 0;
  int   n_errors = 0;

  efpga_tcdm_l2_bridge_if s_if ();
  efpga_tcdm_l2_bridge_if l2_if ();

  efpga_tcdm_l2_bridge dut (
    .asic_clk_i  (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .clr_err_i   (clr_err),
    .s_port      (s_if),
    .l2_port     (l2_if),
    .idle_o      (idle),
    .err_unexp_o (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   grants;
    int   pushed;
    int   popped;
    int   resp;
    int   rx;
    logic pop_prev;
    logic pop_now;

    rst_n = 1'b0; enable = 1'b0; clr_err = 1'b0;
    s_if.req = 1'b0; s_if.add = 32'h0; s_if.wen = 1'b1; s_if.be = 4'h0; s_if.wdata = 32'h0;
    l2_if.gnt = 1'b0; l2_if.r_valid = 1'b0; l2_if.r_rdata = 32'h0;

    // Reset values
    tick(); tick();
    check("rst_s_gnt",   32'(s_if.gnt), 32'd0);
    check("rst_s_rvld",  32'(s_if.r_valid), 32'd0);
    check("rst_s_rdata", s_if.r_rdata, 32'h0);
    check("rst_l2_req",  32'(l2_if.req), 32'd0);
    check("rst_idle",    32'(idle), 32'd1);
    check("rst_err",     32'(err), 32'd0);
    check("rst_l2_add",  l2_if.add, 32'h1C00_0000);
    check("rst_l2_wen",  32'(l2_if.wen), 32'd1);
    check("rst_l2_be",   32'(l2_if.be), 32'd0);
    check("rst_l2_wd",   l2_if.wdata, 32'h0);
    rst_n = 1'b1;

    // Single read; upper address bits must be replaced by BASE_HI
    enable = 1'b1;
    tick();
    s_if.req = 1'b1; s_if.add = 32'hABC1_2340; s_if.wen = 1'b1; s_if.be = 4'hF;
    #1;
    check("t1_gnt", 32'(s_if.gnt), 32'd1);
    check("t1_no_bypass", 32'(l2_if.req), 32'd0);
    tick();
    s_if.req = 1'b0;
    #1;
    check("t1_l2_req", 32'(l2_if.req), 32'd1);
    check("t1_l2_add", l2_if.add, 32'h1C01_2340);
    check("t1_l2_wen", 32'(l2_if.wen), 32'd1);
    check("t1_l2_be",  32'(l2_if.be), 32'hF);
    l2_if.gnt = 1'b1;
    tick();
    l2_if.gnt = 1'b0;
    #1;
    check("t1_req_drop", 32'(l2_if.req), 32'd0);
    check("t1_busy", 32'(idle), 32'd0);
    l2_if.r_valid = 1'b1; l2_if.r_rdata = 32'hCAFE_F00D;
    #1;
    check("t1_rvld_early", 32'(s_if.r_valid), 32'd0);
    tick();
    l2_if.r_valid = 1'b0; l2_if.r_rdata = 32'h0;
    check("t1_rvld", 32'(s_if.r_valid), 32'd1);
    check("t1_rdata", s_if.r_rdata, 32'hCAFE_F00D);
    check("t1_idle", 32'(idle), 32'd1);
    tick();
    check("t1_rvld_pulse", 32'(s_if.r_valid), 32'd0);

    // Burst of 6 writes with L2 stalled: only 4 fit
    s_if.wen = 1'b0; s_if.be = 4'h3;
    for (int i = 0; i < 6; i++) begin
      s_if.req = 1'b1; s_if.add = 32'h100 + 32'(4 * i); s_if.wdata = 32'hA0 + 32'(i);
      #1;
      check($sformatf("t2_gnt%0d", i), 32'(s_if.gnt), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    s_if.req = 1'b0;
    #1;
    check("t2_l2_req", 32'(l2_if.req), 32'd1);
    check("t2_head_add", l2_if.add, 32'h1C00_0100);
    check("t2_head_wd", l2_if.wdata, 32'h0000_00A0);
    check("t2_head_wen", 32'(l2_if.wen), 32'd0);
    check("t2_head_be", 32'(l2_if.be), 32'h3);
    l2_if.gnt = 1'b1;
    grants = 0;
    repeat (5) begin
      #1;
      if (l2_if.req) grants++;
      tick();
    end
    check("t2_grants", 32'(grants), 32'd2);
    check("t2_req_capped", 32'(l2_if.req), 32'd0);
    check("t2_head2_wd", l2_if.wdata, 32'h0000_00A2);
    l2_if.gnt = 1'b0;
    l2_if.r_valid = 1'b1; l2_if.r_rdata = 32'h0000_1111;
    tick();
    l2_if.r_rdata = 32'h0000_2222;
    #1;
    check("t2_r0", s_if.r_rdata, 32'h0000_1111);
    tick();
    l2_if.r_valid = 1'b0;
    #1;
    check("t2_r1", s_if.r_rdata, 32'h0000_2222);
    check("t2_req_again", 32'(l2_if.req), 32'd1);
    l2_if.gnt = 1'b1;
    tick(); tick();
    l2_if.gnt = 1'b0;
    #1;
    check("t2_empty", 32'(l2_if.req), 32'd0);
    l2_if.r_valid = 1'b1; l2_if.r_rdata = 32'h0000_3333;
    tick();
    l2_if.r_rdata = 32'h0000_4444;
    tick();
    l2_if.r_valid = 1'b0;
    #1;
    check("t2_r3", s_if.r_rdata, 32'h0000_4444);
    check("t2_idle", 32'(idle), 32'd1);

    // Back-to-back reads, each response aligned with the next pop
    l2_if.gnt = 1'b1; s_if.wen = 1'b1; s_if.be = 4'hF;
    pushed = 0; popped = 0; resp = 0; rx = 0; pop_prev = 1'b0;
    tick();
    for (int c = 0; c < 16; c++) begin
      if (s_if.r_valid) begin
        check($sformatf("t3_rdata%0d", rx), s_if.r_rdata, 32'hD000_0000 + 32'(rx));
        rx++;
      end
      l2_if.r_valid = pop_prev;
      l2_if.r_rdata = 32'hD000_0000 + 32'(resp);
      if (pop_prev) resp++;
      s_if.req = (pushed < 10);
      s_if.add = 32'h2000 + 32'(16 * pushed);
      #1;
      if (s_if.req) begin
        check($sformatf("t3_gnt%0d", pushed), 32'(s_if.gnt), 32'd1);
        pushed++;
      end
      pop_now = l2_if.req;
      if (pop_now) begin
        check($sformatf("t3_add%0d", popped), l2_if.add, 32'h1C00_2000 + 32'(16 * popped));
        popped++;
        if (l2_if.r_valid) check($sformatf("t3_outst%0d", popped), 32'(dut.r_outst), 32'd1);
      end
      pop_prev = pop_now;
      tick();
    end
    l2_if.gnt = 1'b0; l2_if.r_valid = 1'b0; s_if.req = 1'b0;
    check("t3_popped", 32'(popped), 32'd10);
    check("t3_rx", 32'(rx), 32'd10);
    check("t3_idle", 32'(idle), 32'd1);

    // Disable with 3 queued requests: grant drops at once, queue drains
    for (int i = 0; i < 3; i++) begin
      s_if.req = 1'b1; s_if.add = 32'h3000 + 32'(4 * i);
      tick();
    end
    s_if.add = 32'h300C; enable = 1'b0;
    #1;
    check("t4_gnt_off", 32'(s_if.gnt), 32'd0);
    tick();
    check("t4_gnt_drain", 32'(s_if.gnt), 32'd0);
    s_if.req = 1'b0;
    l2_if.gnt = 1'b1;
    pop_prev = 1'b0; popped = 0; rx = 0;
    for (int c = 0; c < 8; c++) begin
      if (s_if.r_valid) rx++;
      l2_if.r_valid = pop_prev;
      l2_if.r_rdata = 32'hE000_0000 + 32'(c);
      #1;
      pop_now = l2_if.req;
      if (pop_now) begin
        check($sformatf("t4_add%0d", popped), l2_if.add, 32'h1C00_3000 + 32'(4 * popped));
        popped++;
      end
      pop_prev = pop_now;
      tick();
    end
    l2_if.gnt = 1'b0; l2_if.r_valid = 1'b0;
    check("t4_popped", 32'(popped), 32'd3);
    check("t4_rx", 32'(rx), 32'd3);
    check("t4_idle", 32'(idle), 32'd1);
    check("t4_state", 32'(dut.r_state), 32'd0);

    // Stray responses and clear priority
    check("t5_err_pre", 32'(err), 32'd0);
    l2_if.r_valid = 1'b1; l2_if.r_rdata = 32'h5555_AAAA;
    tick();
    l2_if.r_valid = 1'b0;
    check("t5_err_set", 32'(err), 32'd1);
    check("t5_fwd_vld", 32'(s_if.r_valid), 32'd1);
    check("t5_fwd_data", s_if.r_rdata, 32'h5555_AAAA);
    check("t5_no_underflow", 32'(dut.r_outst), 32'd0);
    check("t5_idle", 32'(idle), 32'd1);
    tick();
    check("t5_err_held", 32'(err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t5_err_clr", 32'(err), 32'd0);
    l2_if.r_valid = 1'b1; clr_err = 1'b1;
    tick();
    l2_if.r_valid = 1'b0; clr_err = 1'b0;
    check("t5_set_wins", 32'(err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t5_err_clr2", 32'(err), 32'd0);

    // Reset with 2 outstanding and 2 queued, then a late response
    enable = 1'b1; s_if.wen = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      s_if.req = 1'b1; s_if.add = 32'h4000 + 32'(4 * i); s_if.wdata = 32'h77 + 32'(i);
      tick();
    end
    l2_if.gnt = 1'b1;
    #1;
    check("t6_full_gnt", 32'(s_if.gnt), 32'd0);
    tick();
    s_if.req = 1'b0;
    tick();
    l2_if.gnt = 1'b0;
    #1;
    check("t6_capped", 32'(l2_if.req), 32'd0);
    check("t6_busy", 32'(idle), 32'd0);
    #2;
    rst_n = 1'b0; enable = 1'b0;
    #1;
    check("t6_rst_l2_req", 32'(l2_if.req), 32'd0);
    check("t6_rst_idle",   32'(idle), 32'd1);
    check("t6_rst_gnt",    32'(s_if.gnt), 32'd0);
    check("t6_rst_err",    32'(err), 32'd0);
    check("t6_rst_rvld",   32'(s_if.r_valid), 32'd0);
    check("t6_rst_add",    l2_if.add, 32'h1C00_0000);
    check("t6_rst_wen",    32'(l2_if.wen), 32'd1);
    check("t6_rst_wd",     l2_if.wdata, 32'h0);
    tick();
    rst_n = 1'b1;
    l2_if.r_valid = 1'b1; l2_if.r_rdata = 32'h0000_BEEF;
    tick();
    l2_if.r_valid = 1'b0;
    check("t6_late_err", 32'(err), 32'd1);
    check("t6_late_fwd", s_if.r_rdata, 32'h0000_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
